// File: rtl/jpeg_stream_framer.sv
// Wraps entropy-coded bytes into a JFIF stream: header (quant table patched from EBR), 0xFF stuffing, EOI.
// One registered output byte; holds under out_ready=0, header runs 1 byte/cycle after a 1-cycle prefetch.
module jpeg_stream_framer #(
  parameter int HEADER_LEN   = 328,
  parameter int QUANT_OFFSET = 25,
  parameter int QUANT_LEN    = 64,
  parameter int COUNT_W      = 20
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic [7:0]         ec_data,
  input  logic               ec_valid,
  output logic               ec_ready,
  output logic [8:0]         hdr_addr,
  input  logic [7:0]         hdr_data,
  output logic [5:0]         qt_addr,
  input  logic [7:0]         qt_data,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [COUNT_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_STUFF, S_EOI_FF, S_EOI_D9, S_DRAIN
  } state_t;

  localparam logic [8:0] HDR_LAST = 9'(HEADER_LEN - 1);
  localparam logic [8:0] Q_LO     = 9'(QUANT_OFFSET);
  localparam logic [8:0] Q_HI     = 9'(QUANT_OFFSET + QUANT_LEN);

  state_t             state_q, state_d;
  logic [8:0]         idx_q, idx_d;
  logic               qsel_q, qsel_d;
  logic               end_q, end_d;
  logic               busy_q, busy_d;
  logic [7:0]         out_dat_q, out_dat_d;
  logic               out_vld_q, out_vld_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               out_free;
  logic               load;
  logic [7:0]         load_dat;

  always_comb begin
    out_free  = !out_vld_q || out_ready;
    ec_ready  = (state_q == S_DATA) && out_free && !end_q;
    state_d   = state_q;
    idx_d     = idx_q;
    end_d     = end_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_dat  = 8'h00;
    hdr_addr  = 9'd0;

    if (state_q != S_IDLE && frame_end) end_d = 1'b1;
    if (out_vld_q && out_ready && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_HEADER;
          idx_d   = 9'd0;
          end_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_HEADER: begin
        // idx_q is the byte whose ROM/EBR data is on the bus now; re-read it while stalled.
        hdr_addr = idx_q;
        if (out_free) begin
          load     = 1'b1;
          load_dat = qsel_q ? qt_data : hdr_data;
          hdr_addr = idx_q + 9'd1;
          if (idx_q == HDR_LAST) state_d = S_DATA;
        end
        idx_d = hdr_addr;
      end
      S_DATA: begin
        if (ec_ready && ec_valid) begin
          load     = 1'b1;
          load_dat = ec_data;
          if (ec_data == 8'hFF) state_d = S_STUFF;
        end else if (end_q && out_free) begin
          state_d = S_EOI_FF;
        end
      end
      S_STUFF: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = S_DATA;
        end
      end
      S_EOI_FF: begin
        if (out_free) begin
          load     = 1'b1;
          load_dat = 8'hFF;
          state_d  = S_EOI_D9;
        end
      end
      S_EOI_D9: begin
        if (out_free) begin
          load     = 1'b1;
          load_dat = 8'hD9;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_vld_q && out_ready) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          end_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    qsel_d    = (hdr_addr >= Q_LO) && (hdr_addr < Q_HI);
    qt_addr   = qsel_d ? 6'(hdr_addr - Q_LO) : 6'd0;
    out_dat_d = load ? load_dat : out_dat_q;
    out_vld_d = load ? 1'b1 : (out_ready ? 1'b0 : out_vld_q);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      idx_q     <= 9'd0;
      qsel_q    <= 1'b0;
      end_q     <= 1'b0;
      busy_q    <= 1'b0;
      out_dat_q <= 8'h00;
      out_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      qsel_q    <= qsel_d;
      end_q     <= end_d;
      busy_q    <= busy_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_data   = out_dat_q;
  assign out_valid  = out_vld_q;
  assign busy       = busy_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_jpeg_stream_framer.sv
// Bench for jpeg_stream_framer: ROM/EBR models, expected-byte scoreboard, per-scenario tasks.
module tb_jpeg_stream_framer;
  localparam int HL = 328;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic [7:0]  ec_data = 8'h00;
  logic        ec_valid = 1'b0;
  logic        ec_ready;
  logic [8:0]  hdr_addr;
  logic [7:0]  hdr_data = 8'h00;
  logic [5:0]  qt_addr;
  logic [7:0]  qt_data = 8'h00;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic [19:0] byte_count;

  logic [7:0] hdr_rom [512];
  logic [7:0] qt_mem [64];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ec_src[$];

  int tests_run = 0;
  int tests_failed = 0;
  bit bp_mode = 1'b0;
  int stab_err = 0;
  bit hold_prev = 1'b0;
  logic [7:0] hold_dat = 8'h00;

  int cfg_fe_cyc, cfg_fe_byte, cfg_fs_byte, cfg_rst_byte;
  bit cfg_hold_aa;
  int first_cyc, hdr_cyc, stuff_err, stuff_seen;
  logic [19:0] cnt_c2, rst_cnt;
  logic rst_ov, rst_busy;

  jpeg_stream_framer dut (
    .clock(clock), .nreset(nreset), .frame_start(frame_start), .frame_end(frame_end),
    .ec_data(ec_data), .ec_valid(ec_valid), .ec_ready(ec_ready),
    .hdr_addr(hdr_addr), .hdr_data(hdr_data), .qt_addr(qt_addr), .qt_data(qt_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    hdr_data <= hdr_rom[hdr_addr];
    qt_data  <= qt_mem[qt_addr];
  end

  always @(posedge clock) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Capture sink transfers and tally any change of a held (stalled) output byte.
  always @(negedge clock) begin
    if (!nreset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (out_valid !== 1'b1 || out_data !== hold_dat)) stab_err++;
      hold_prev = out_valid && !out_ready;
      hold_dat  = out_data;
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic configure(input int fe_cyc, input int fe_byte, input int fs_byte,
                           input int rst_byte, input bit hold_aa);
    cfg_fe_cyc = fe_cyc; cfg_fe_byte = fe_byte; cfg_fs_byte = fs_byte;
    cfg_rst_byte = rst_byte; cfg_hold_aa = hold_aa;
  endtask

  // Expected stream model: header with quant patch, stuffed entropy bytes, EOI.
  task automatic push_frame();
    for (int i = 0; i < HL; i++)
      exp_q.push_back((i >= 25 && i < 89) ? qt_mem[i-25] : hdr_rom[i]);
    foreach (ec_src[i]) begin
      exp_q.push_back(ec_src[i]);
      if (ec_src[i] == 8'hFF) exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'h00;
  endfunction

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  // Drives one frame from frame_start until busy drops (or a cycle budget expires).
  task automatic run_frame(output bit done);
    bit acc, fe_sent, fs_sent, rst_sent, last_ff;
    acc = 0; fe_sent = 0; fs_sent = 0; rst_sent = 0; last_ff = 0;
    done = 0; first_cyc = -1; hdr_cyc = -1; stuff_err = 0; stuff_seen = 0;
    cnt_c2 = '1; rst_cnt = '1; rst_ov = 1'b1; rst_busy = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clock); #1;
      frame_start = 1'b0; frame_end = 1'b0; nreset = 1'b1;
      if (acc) void'(ec_src.pop_front());
      acc = 0;
      if (cfg_hold_aa) begin
        ec_valid = 1'b1; ec_data = 8'hAA;
      end else if (ec_src.size() > 0) begin
        ec_valid = 1'b1; ec_data = ec_src[0];
      end else begin
        ec_valid = 1'b0; ec_data = 8'h00;
        if (cfg_fe_cyc < 0 && cfg_fe_byte < 0 && !fe_sent) begin frame_end = 1'b1; fe_sent = 1; end
      end
      if (cfg_fe_cyc == c && !fe_sent) begin frame_end = 1'b1; fe_sent = 1; end
      if (cfg_fe_byte >= 0 && !fe_sent && got_q.size() >= cfg_fe_byte) begin frame_end = 1'b1; fe_sent = 1; end
      if (cfg_fs_byte >= 0 && !fs_sent && got_q.size() >= cfg_fs_byte) begin frame_start = 1'b1; fs_sent = 1; end
      if (cfg_rst_byte >= 0 && !rst_sent && got_q.size() >= cfg_rst_byte) begin nreset = 1'b0; rst_sent = 1; end
      @(negedge clock);
      if (!nreset) begin rst_ov = out_valid; rst_busy = busy; rst_cnt = byte_count; end
      if (last_ff) begin
        stuff_seen++;
        if (ec_ready) stuff_err++;
      end
      acc = ec_valid && ec_ready;
      last_ff = acc && (ec_data == 8'hFF);
      if (first_cyc < 0 && out_valid) first_cyc = c;
      if (hdr_cyc < 0 && got_q.size() >= HL) hdr_cyc = c;
      if (c == 2) cnt_c2 = byte_count;
      if (!busy) begin done = 1; break; end
    end
    frame_start = 1'b0; frame_end = 1'b0; ec_valid = 1'b0;
    if (!nreset) begin @(posedge clock); #1; nreset = 1'b1; end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data: got %02h want 00", out_data); end
    tests_run++; if (ec_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ec_ready: got %b want 0", ec_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (byte_count !== 20'd0) begin tests_failed++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
    tests_run++; if (hdr_addr !== 9'd0) begin tests_failed++; $display("FAIL reset_hdr_addr: got %0d want 0", hdr_addr); end
    tests_run++; if (qt_addr !== 6'd0) begin tests_failed++; $display("FAIL reset_qt_addr: got %0d want 0", qt_addr); end
    @(posedge clock); #1;
    nreset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_header_frame();
    bit done;
    int d;
    for (int i = 0; i < 64; i++) qt_mem[i] = 8'h01;
    clear_sb(); ec_src.delete(); bp_mode = 0;
    configure(3, -1, -1, -1, 0);
    push_frame();
    run_frame(done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL hdr_timeout: busy still %b want 0", busy); end
    d = first_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL hdr_stream: byte %0d got %02h want %02h (len %0d want %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    tests_run++; if (byte_count !== 20'd330) begin tests_failed++; $display("FAIL hdr_byte_count: got %0d want 330", byte_count); end
    tests_run++; if (first_cyc < 1 || first_cyc > 2) begin tests_failed++; $display("FAIL hdr_first_latency: got %0d cycles want <=2", first_cyc); end
    tests_run++; if (hdr_cyc < 0 || hdr_cyc > 330) begin tests_failed++; $display("FAIL hdr_done_latency: got %0d cycles want <=330", hdr_cyc); end
  endtask

  task automatic run_stuffing(input string tag, input bit bp);
    bit done;
    int d;
    for (int i = 0; i < 64; i++) qt_mem[i] = 8'(8'h40 + i);
    clear_sb(); bp_mode = bp;
    ec_src = '{8'h12, 8'hFF, 8'h34, 8'hFF, 8'hFF};
    configure(-1, -1, -1, -1, 0);
    push_frame();
    run_frame(done);
    bp_mode = 0;
    tests_run++; if (!done) begin tests_failed++; $display("FAIL %s_timeout: busy still %b want 0", tag, busy); end
    d = first_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL %s_stream: byte %0d got %02h want %02h (len %0d want %0d)", tag, d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    tests_run++; if (stuff_err != 0 || stuff_seen != 3) begin tests_failed++; $display("FAIL %s_stuff_ready: ec_ready high in %0d of %0d stuff cycles, want 0 of 3", tag, stuff_err, stuff_seen); end
    tests_run++; if (byte_count !== 20'd338) begin tests_failed++; $display("FAIL %s_byte_count: got %0d want 338", tag, byte_count); end
  endtask

  task automatic test_stuffing();
    run_stuffing("stuff", 0);
  endtask

  task automatic test_backpressure();
    stab_err = 0;
    run_stuffing("bp", 1);
    tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL bp_hold_stable: %0d changes while stalled, want 0", stab_err); end
  endtask

  task automatic test_end_in_header();
    bit done;
    int d;
    clear_sb(); ec_src.delete(); bp_mode = 0;
    configure(-1, 50, 100, -1, 1);
    push_frame();
    run_frame(done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL endhdr_timeout: busy still %b want 0", busy); end
    d = first_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL endhdr_stream: byte %0d got %02h want %02h (len %0d want %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    tests_run++; if (byte_count !== 20'd330) begin tests_failed++; $display("FAIL endhdr_byte_count: got %0d want 330", byte_count); end
  endtask

  task automatic test_reset_mid_frame();
    bit done;
    int d;
    clear_sb(); ec_src.delete(); bp_mode = 0;
    configure(-1, -1, -1, 100, 0);
    run_frame(done);
    tests_run++; if (rst_ov !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b want 0", rst_ov); end
    tests_run++; if (rst_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", rst_busy); end
    tests_run++; if (rst_cnt !== 20'd0) begin tests_failed++; $display("FAIL rst_byte_count: got %0d want 0", rst_cnt); end
    clear_sb();
    configure(-1, -1, -1, -1, 0);
    push_frame();
    run_frame(done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL rst_restart_timeout: busy still %b want 0", busy); end
    tests_run++; if (got_at(0) !== 8'hFF || got_at(1) !== 8'hD8) begin tests_failed++; $display("FAIL rst_restart_soi: got %02h %02h want ff d8", got_at(0), got_at(1)); end
    d = first_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL rst_restart_stream: byte %0d got %02h want %02h (len %0d want %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    tests_run++; if (byte_count !== 20'd330) begin tests_failed++; $display("FAIL rst_restart_count: got %0d want 330", byte_count); end
  endtask

  task automatic test_back_to_back();
    bit done_a, done_b;
    int d;
    clear_sb(); bp_mode = 0;
    configure(-1, -1, -1, -1, 0);
    ec_src = '{8'h55};
    push_frame();
    run_frame(done_a);
    tests_run++; if (byte_count !== 20'd331) begin tests_failed++; $display("FAIL b2b_count_a: got %0d want 331", byte_count); end
    ec_src = '{8'hFF, 8'h7F};
    push_frame();
    run_frame(done_b);
    tests_run++; if (!done_a || !done_b) begin tests_failed++; $display("FAIL b2b_timeout: frame done %b %b want 1 1", done_a, done_b); end
    tests_run++; if (cnt_c2 !== 20'd0) begin tests_failed++; $display("FAIL b2b_count_clear: got %0d want 0", cnt_c2); end
    tests_run++; if (byte_count !== 20'd333) begin tests_failed++; $display("FAIL b2b_count_b: got %0d want 333", byte_count); end
    tests_run++; if (got_at(331) !== 8'hFF || got_at(332) !== 8'hD8) begin tests_failed++; $display("FAIL b2b_second_soi: got %02h %02h want ff d8", got_at(331), got_at(332)); end
    d = first_diff();
    tests_run++; if (d >= 0) begin tests_failed++; $display("FAIL b2b_stream: byte %0d got %02h want %02h (len %0d want %0d)", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) hdr_rom[i] = 8'(i * 37 + 11);
    hdr_rom[0] = 8'hFF;
    hdr_rom[1] = 8'hD8;
    for (int i = 0; i < 64; i++) qt_mem[i] = 8'h01;
    test_reset();
    test_header_frame();
    test_stuffing();
    test_backpressure();
    test_end_in_header();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jpeg_stream_framer.md
Name: jpeg_stream_framer

Overview:
Output-side sequencer for the jfpjc compressor. It wraps the entropy-coded byte stream into a complete JFIF file. Per frame it emits the fixed JPEG header from the header ROM, patching the 64-byte quantization segment from the live quantization-table EBR. It then forwards entropy-coded bytes with 0xFF byte stuffing and closes with EOI (FF D9). Sits between the Huffman stage and the byte sink (UART/FIFO/testbench capture).

Parameters:
HEADER_LEN, 328, header length in bytes (header ROM depth used)
QUANT_OFFSET, 25, byte index of first quantization-table entry within header
QUANT_LEN, 64, number of quantization bytes patched from EBR
COUNT_W, 20, width of byte_count

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse: new frame begins (from vsync edge)
frame_end  in  1  single-cycle pulse: no more entropy bytes for this frame (flush done)
ec_data  in  8  entropy-coded byte from Huffman stage
ec_valid  in  1  ec_data valid
ec_ready  out  1  framer accepts ec_data this cycle
hdr_addr  out  9  header ROM address; ROM has 1-cycle synchronous read latency
hdr_data  in  8  header ROM data
qt_addr  out  6  quantization EBR address; 1-cycle read latency
qt_data  in  8  quantization EBR data
out_data  out  8  framed output byte (registered)
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts out_data
busy  out  1  high from accepted frame_start until EOI D9 accepted
byte_count  out  COUNT_W  bytes accepted by sink in current/last frame

Behaviour:
- Reset (async, nreset=0): state IDLE; out_valid=0, out_data=0, ec_ready=0, busy=0, byte_count=0, hdr_addr=0, qt_addr=0, internal end flag cleared. Reset mid-frame aborts immediately; no partial EOI.
- Transfer on out: byte moves when out_valid&&out_ready. While out_valid&&!out_ready, out_data and out_valid hold stable.
- Transfer on ec: byte moves when ec_valid&&ec_ready. ec_ready is combinational from state and output-register availability; never depends on ec_valid.
- Output register is "free" when out_valid=0 or out_ready=1.
- byte_count: cleared on accepted frame_start, +1 per out transfer, saturates at all-ones, holds after EOI until next frame.
- States:
  - IDLE: frame_start -> HEADER, index p=0, busy=1. frame_end in IDLE is ignored.
  - HEADER: hdr_addr/qt_addr present the index of the byte to load on the next free edge. Byte p = qt_data[p-QUANT_OFFSET] if QUANT_OFFSET<=p<QUANT_OFFSET+QUANT_LEN, else hdr_data[p]. The source select is registered so it aligns with ROM latency. Throughput is 1 byte/cycle with out_ready=1 after a 1-cycle prefetch. After byte HEADER_LEN-1 is loaded -> DATA.
  - DATA: ec_ready = output free. Accepted byte != 0xFF is loaded. Accepted 0xFF is loaded, then -> STUFF. If the end flag is set and no stuff is pending -> EOI_FF once the register is free.
  - STUFF: ec_ready=0; load 0x00 when free -> DATA.
  - EOI_FF: load 0xFF -> EOI_D9. EOI_D9: load 0xD9 -> DRAIN. DRAIN: when the D9 transfer completes -> IDLE, busy=0.
- frame_end is latched into the end flag in any non-IDLE state, including HEADER. An ec byte accepted in the same cycle as frame_end is still emitted, with stuffing, before EOI. Entropy bytes arriving after frame_end are not accepted (ec_ready=0).
- frame_start while busy: ignored (no restart, no count clear).
- Simultaneous frame_start and final D9 transfer: new frame is not started; frame_start must be re-asserted in IDLE.
- The header ROM is expected to contain FF D8 at bytes 0-1; the framer does not stuff header bytes.

Test Plan:
1. frame_start, then frame_end 3 cycles later, out_ready=1 -> exactly 330 bytes: header ROM bytes with 25..88 equal to EBR contents (load all-1s table -> 64×0x01), then FF D9; byte_count=330; first byte out ≤2 cycles after frame_start; header done in ≤330 cycles.
2. After header, ec bytes 12,FF,34,FF,FF then frame_end -> stream tail 12 FF 00 34 FF 00 FF 00 FF D9; ec_ready low in each STUFF cycle.
3. Backpressure: out_ready pseudo-random 50% over test 2 stream -> identical byte sequence; out_data never changes while out_valid&&!out_ready.
4. frame_end pulsed during HEADER byte 50, then ec_valid held with 0xAA -> no AA bytes emitted; stream = header+FF D9. frame_start pulsed at byte 100 of header -> ignored, byte_count continues.
5. nreset low at header byte 100 for 1 cycle -> out_valid=0, busy=0, byte_count=0 asynchronously; next frame_start restarts at byte 0 (FF D8), complete 330-byte frame.
6. Two back-to-back frames (frame_start one cycle after D9 accepted) -> two well-formed JFIF images; byte_count resets between them; output parses as valid JPEG.
